wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

- Schedules the single integer register-file write port among three producers: the execute stage, the 5-stage multiplier (mult5) and the data cache.
- Replaces the fixed-priority, drop-on-conflict writeback selection with lossless arbitration:
  - one holding slot per producer;
  - registered grant;
  - per-source stall back-pressure;
  - bounded-wait starvation override.
- Sits between the producers and the writeback stage; its registered outputs feed the register file write port directly.

## Interface

Parameters:
- STARVE_LIMIT, 4: cycles a buffered entry may wait ungranted before it gains top priority (legal range 1..15).

Ports. S ∈ {exe, mult5, cache}; each S has the seven S_ ports listed.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- kill_i  in  1  pipeline flush; same effect as reset on state.
- S_valid_i  in  1  S presents an entry this cycle.
- S_write_data_i  in  32  result value.
- S_write_addr_i  in  5  destination register.
- S_exc_bits_i  in  32  exception bits; already final, the exe illegal-instruction bit is OR-ed in upstream.
- S_instruction_i  in  32  instruction word.
- S_pc_i  in  32  PC.
- S_stall_o  out  1  S's slot is occupied; S must not assert S_valid_i while high.
- write_int_write_data_o  out  32  granted data.
- write_write_addr_o  out  5  granted destination.
- write_int_write_enable_o  out  1  write strobe.
- write_exc_bits_o  out  32  granted exception bits.
- write_instruction_o  out  32  granted instruction.
- write_pc_o  out  32  granted PC.
- write_grant_src_o  out  2  0 none, 1 exe, 2 mult5, 3 cache.

## Operation

- **Candidate per source:** the slot content if the slot is full, otherwise the incoming entry if S_valid_i is high.
- **Base priority:** mult5 > cache > exe.
- **Starvation:**
  - Each slot has a wait counter. It increments each cycle the slot is full and not granted, saturating at STARVE_LIMIT.
  - A slot whose counter equals STARVE_LIMIT is starved; any starved candidate beats every non-starved one.
  - Among several starved slots, base priority applies.
- **Grant:** exactly one candidate, or none. The granted entry is registered into the write_* outputs with enable 1 and grant_src set.
  - If the granted entry came from a slot, the slot empties and its counter clears.
- **Capture:** a non-granted incoming entry is written into its (empty) slot, counter 0.
- **No candidate:** enable 0 and grant_src 0; the data, addr, exc, instruction and pc outputs hold their last values.
- **Register x0:** an entry with write_addr 0 is granted and emitted normally; the register file ignores it.
- **Protocol violation:** S_valid_i high while S_stall_o is high. The incoming entry is dropped and the slot keeps its content; the bench flags this as an error.
- **kill_i or rst_i high at an edge:**
  - all slots empty, all counters 0, all stalls 0;
  - incoming entries that cycle are discarded.
- **Outputs under reset only:** all write_* outputs are 0 and grant_src is 0. kill_i alone clears only enable and grant_src.

## Timing

- Latency: an entry granted on arrival at edge N is visible from cycle N+1, i.e. one cycle.
- Throughput: one write per cycle on the port.
- A single uncontended source sustains one entry per cycle with S_stall_o never asserted.
- S_stall_o is registered: it goes high the cycle after capture and low the cycle after the slot is granted.
- A contended source therefore issues at most one entry every 2 cycles.
- Worst-case wait of a buffered entry is STARVE_LIMIT + 2 cycles, since at most two other slots can be starved simultaneously.
- Reset values: all outputs 0, including every S_stall_o.

## Structure

- **Package wb_arb_pkg:**
  - source encoding constants SRC_NONE, SRC_EXE, SRC_MULT5, SRC_CACHE;
  - packed entry type wb_entry_t: data 32, addr 5, exc 32, instruction 32, pc 32 (133 bits);
  - the starvation counter width constant (4 bits).
- **Sub-module wb_src_slot:**
  - one-entry buffer, valid flag and saturating wait counter;
  - exposes candidate, candidate-valid, starved and stall;
  - inputs are incoming entry, grant, kill and reset;
  - instantiated once per source.
- **Top level:** priority/starvation select and the output register.

## Test plan

1. **Reset:** hold rst_i 2 cycles with all valids high → every output 0, stalls 0, no capture. First cycle after release with no valids → enable 0.
2. **Three-way collision:** exe (addr 1), mult5 (addr 2), cache (addr 3) valid at edge 0 → outputs show addr 2 in cycle 1, addr 3 in cycle 2, addr 1 in cycle 3. cache_stall_o high in cycle 1 only; exe_stall_o high in cycles 1–2.
3. **Starvation (STARVE_LIMIT=4):** mult5 valid every cycle from edge 0, exe valid once at edge 0 (addr 7) → exe granted at edge 5, addr 7 visible in cycle 6 with grant_src 1. The mult5 entry of edge 5 is buffered, mult5_stall_o high in cycle 6, mult5 output resumes in cycle 7.
4. **Flush:** exe and cache slots full, kill_i at edge N → cycle N+1 has enable 0, all stalls 0, and neither buffered entry ever appears.
5. **Back-to-back single source:** cache valid for 8 consecutive cycles, addrs 1..8 → addrs 1..8 emitted in cycles 1..8, cache_stall_o never high.
6. **Mid-operation reset:** slots full and counters nonzero, rst_i at edge N → cycle N+1 shows all outputs 0 including data/pc. The next grant after release starts from clean counters.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
// The source encoding here is also the encoding of write_grant_src_o.
package wb_arb_pkg;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_EXE   = 2'd1;
    localparam logic [1:0] SRC_MULT5 = 2'd2;
    localparam logic [1:0] SRC_CACHE = 2'd3;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] exc;
        logic [31:0] instruction;
        logic [31:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/wb_src_slot.sv
// One-entry holding slot for a single writeback producer, with a saturating
// wait counter that marks the buffered entry as starved.
module wb_src_slot
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      kill_i,
    input  logic      in_valid_i,
    input  wb_entry_t in_entry_i,
    input  logic      grant_i,
    output wb_entry_t cand_o,
    output logic      cand_valid_o,
    output logic      starved_o,
    output logic      stall_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             full_q, full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    wb_entry_t        entry_q, entry_d;

    // A full slot always shadows the incoming entry; incoming data while full
    // is a protocol violation and is simply ignored.
    assign cand_o       = full_q ? entry_q : in_entry_i;
    assign cand_valid_o = full_q | in_valid_i;
    assign starved_o    = full_q && (cnt_q == LIMIT);
    assign stall_o      = full_q;

    always_comb begin
        full_d  = full_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        if (rst_i || kill_i) begin
            full_d = 1'b0;
            cnt_d  = '0;
        end else if (full_q) begin
            if (grant_i) begin
                full_d = 1'b0;
                cnt_d  = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (in_valid_i && !grant_i) begin
            full_d  = 1'b1;
            cnt_d   = '0;
            entry_d = in_entry_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload is qualified by full_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Lossless arbiter for the single integer register-file write port shared by
// the execute stage, the 5-stage multiplier and the data cache.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        kill_i,

    input  logic        exe_valid_i,
    input  logic [31:0] exe_write_data_i,
    input  logic [4:0]  exe_write_addr_i,
    input  logic [31:0] exe_exc_bits_i,
    input  logic [31:0] exe_instruction_i,
    input  logic [31:0] exe_pc_i,
    output logic        exe_stall_o,

    input  logic        mult5_valid_i,
    input  logic [31:0] mult5_write_data_i,
    input  logic [4:0]  mult5_write_addr_i,
    input  logic [31:0] mult5_exc_bits_i,
    input  logic [31:0] mult5_instruction_i,
    input  logic [31:0] mult5_pc_i,
    output logic        mult5_stall_o,

    input  logic        cache_valid_i,
    input  logic [31:0] cache_write_data_i,
    input  logic [4:0]  cache_write_addr_i,
    input  logic [31:0] cache_exc_bits_i,
    input  logic [31:0] cache_instruction_i,
    input  logic [31:0] cache_pc_i,
    output logic        cache_stall_o,

    output logic [31:0] write_int_write_data_o,
    output logic [4:0]  write_write_addr_o,
    output logic        write_int_write_enable_o,
    output logic [31:0] write_exc_bits_o,
    output logic [31:0] write_instruction_o,
    output logic [31:0] write_pc_o,
    output logic [1:0]  write_grant_src_o
);

    wb_entry_t exe_in, mult5_in, cache_in;
    wb_entry_t exe_cand, mult5_cand, cache_cand;
    logic      exe_cv, mult5_cv, cache_cv;
    logic      exe_st, mult5_st, cache_st;
    logic [1:0] sel;
    wb_entry_t  sel_entry;

    assign exe_in   = '{exe_write_data_i, exe_write_addr_i, exe_exc_bits_i,
                        exe_instruction_i, exe_pc_i};
    assign mult5_in = '{mult5_write_data_i, mult5_write_addr_i, mult5_exc_bits_i,
                        mult5_instruction_i, mult5_pc_i};
    assign cache_in = '{cache_write_data_i, cache_write_addr_i, cache_exc_bits_i,
                        cache_instruction_i, cache_pc_i};

    wb_src_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_exe_slot (
        .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
        .in_valid_i(exe_valid_i), .in_entry_i(exe_in), .grant_i(sel == SRC_EXE),
        .cand_o(exe_cand), .cand_valid_o(exe_cv), .starved_o(exe_st),
        .stall_o(exe_stall_o)
    );

    wb_src_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_mult5_slot (
        .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
        .in_valid_i(mult5_valid_i), .in_entry_i(mult5_in), .grant_i(sel == SRC_MULT5),
        .cand_o(mult5_cand), .cand_valid_o(mult5_cv), .starved_o(mult5_st),
        .stall_o(mult5_stall_o)
    );

    wb_src_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_cache_slot (
        .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
        .in_valid_i(cache_valid_i), .in_entry_i(cache_in), .grant_i(sel == SRC_CACHE),
        .cand_o(cache_cand), .cand_valid_o(cache_cv), .starved_o(cache_st),
        .stall_o(cache_stall_o)
    );

    // Any starved slot outranks every fresh candidate; ties use mult5 > cache > exe.
    always_comb begin
        sel = SRC_NONE;
        if (mult5_st || cache_st || exe_st) begin
            if (mult5_st)      sel = SRC_MULT5;
            else if (cache_st) sel = SRC_CACHE;
            else               sel = SRC_EXE;
        end else if (mult5_cv) begin
            sel = SRC_MULT5;
        end else if (cache_cv) begin
            sel = SRC_CACHE;
        end else if (exe_cv) begin
            sel = SRC_EXE;
        end
    end

    always_comb begin
        case (sel)
            SRC_EXE:   sel_entry = exe_cand;
            SRC_MULT5: sel_entry = mult5_cand;
            SRC_CACHE: sel_entry = cache_cand;
            default:   sel_entry = '0;
        endcase
    end

    wb_entry_t  out_q, out_d;
    logic       en_q, en_d;
    logic [1:0] src_q, src_d;

    // Payload holds when idle or killed; only a reset clears it.
    always_comb begin
        out_d = out_q;
        en_d  = 1'b0;
        src_d = SRC_NONE;
        if (rst_i) begin
            out_d = '0;
        end else if (!kill_i && sel != SRC_NONE) begin
            out_d = sel_entry;
            en_d  = 1'b1;
            src_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q  <= 1'b0;
            src_q <= SRC_NONE;
        end else begin
            en_q  <= en_d;
            src_q <= src_d;
        end
        out_q <= out_d;
    end

    assign write_int_write_data_o   = out_q.data;
    assign write_write_addr_o       = out_q.addr;
    assign write_exc_bits_o         = out_q.exc;
    assign write_instruction_o      = out_q.instruction;
    assign write_pc_o               = out_q.pc;
    assign write_int_write_enable_o = en_q;
    assign write_grant_src_o        = src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector-table bench for wb_port_arbiter: each record gives one cycle of
// stimulus and the outputs expected right after that rising edge.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b0, kill_i = 1'b0;
    logic        exe_valid_i = 1'b0, mult5_valid_i = 1'b0, cache_valid_i = 1'b0;
    logic [4:0]  exe_a = '0, mult5_a = '0, cache_a = '0;
    logic        exe_stall_o, mult5_stall_o, cache_stall_o;
    logic [31:0] wdata, wexc, winstr, wpc;
    logic [4:0]  waddr;
    logic        wen;
    logic [1:0]  wsrc;

    // Payload fields are derived from (source, addr) so every output field can
    // be predicted; source 0 means the all-zero reset payload.
    function automatic logic [31:0] f_data(input logic [1:0] s, input logic [4:0] a);
        return (s == 2'd0) ? 32'h0 : {8'hDA, 6'b0, s, 11'b0, a};
    endfunction
    function automatic logic [31:0] f_exc(input logic [1:0] s, input logic [4:0] a);
        return (s == 2'd0) ? 32'h0 : {s, 25'b0, a};
    endfunction
    function automatic logic [31:0] f_ins(input logic [1:0] s, input logic [4:0] a);
        return (s == 2'd0) ? 32'h0 : ~{8'hDA, 6'b0, s, 11'b0, a};
    endfunction
    function automatic logic [31:0] f_pc(input logic [1:0] s, input logic [4:0] a);
        return (s == 2'd0) ? 32'h0 : {4'h1, 18'b0, s, 1'b0, a, 2'b0};
    endfunction

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .kill_i(kill_i),
        .exe_valid_i(exe_valid_i), .exe_write_data_i(f_data(2'd1, exe_a)),
        .exe_write_addr_i(exe_a), .exe_exc_bits_i(f_exc(2'd1, exe_a)),
        .exe_instruction_i(f_ins(2'd1, exe_a)), .exe_pc_i(f_pc(2'd1, exe_a)),
        .exe_stall_o(exe_stall_o),
        .mult5_valid_i(mult5_valid_i), .mult5_write_data_i(f_data(2'd2, mult5_a)),
        .mult5_write_addr_i(mult5_a), .mult5_exc_bits_i(f_exc(2'd2, mult5_a)),
        .mult5_instruction_i(f_ins(2'd2, mult5_a)), .mult5_pc_i(f_pc(2'd2, mult5_a)),
        .mult5_stall_o(mult5_stall_o),
        .cache_valid_i(cache_valid_i), .cache_write_data_i(f_data(2'd3, cache_a)),
        .cache_write_addr_i(cache_a), .cache_exc_bits_i(f_exc(2'd3, cache_a)),
        .cache_instruction_i(f_ins(2'd3, cache_a)), .cache_pc_i(f_pc(2'd3, cache_a)),
        .cache_stall_o(cache_stall_o),
        .write_int_write_data_o(wdata), .write_write_addr_o(waddr),
        .write_int_write_enable_o(wen), .write_exc_bits_o(wexc),
        .write_instruction_o(winstr), .write_pc_o(wpc),
        .write_grant_src_o(wsrc)
    );

    typedef struct {
        logic       rst, kill;
        logic [2:0] vld;      // {cache, mult5, exe}
        logic [4:0] ae, am, ac;
        logic       en;
        logic [1:0] src;
        logic [4:0] addr;
        logic [1:0] dsrc;     // producer whose payload should be on the port
        logic [2:0] stall;    // {cache, mult5, exe}
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic k, input logic [2:0] v,
                       input int ae, input int am, input int ac,
                       input logic en, input int src, input int addr,
                       input int dsrc, input logic [2:0] st);
        vec_t t;
        t.rst = r; t.kill = k; t.vld = v;
        t.ae = 5'(ae); t.am = 5'(am); t.ac = 5'(ac);
        t.en = en; t.src = 2'(src); t.addr = 5'(addr); t.dsrc = 2'(dsrc);
        t.stall = st;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL v%0d %s: got %h, required %h", idx, nm, act, req);
        end
    endtask

    task automatic idle(input logic en, input int src, input int addr, input int dsrc,
                        input logic [2:0] st);
        add(0, 0, 3'b000, 0, 0, 0, en, src, addr, dsrc, st);
    endtask

    initial begin
        // Reset with all producers asserting valid: nothing captured.
        add(1, 0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b000);
        add(1, 0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b000);
        idle(0, 0, 0, 0, 3'b000);
        // Three-way collision.
        add(0, 0, 3'b111, 1, 2, 3, 1, 2, 2, 2, 3'b101);
        idle(1, 3, 3, 3, 3'b001);
        idle(1, 1, 1, 1, 3'b000);
        idle(0, 0, 1, 1, 3'b000);
        // Starvation override: exe waits behind a steady mult5 stream.
        add(0, 0, 3'b011, 7, 10, 0, 1, 2, 10, 2, 3'b001);
        for (int k = 11; k <= 14; k++) add(0, 0, 3'b010, 0, k, 0, 1, 2, k, 2, 3'b001);
        add(0, 0, 3'b010, 0, 15, 0, 1, 1, 7, 1, 3'b010);
        idle(1, 2, 15, 2, 3'b000);
        add(0, 0, 3'b010, 0, 16, 0, 1, 2, 16, 2, 3'b000);
        idle(0, 0, 16, 2, 3'b000);
        // Flush with exe and cache buffered; kill also drops a fresh mult5 entry.
        add(0, 0, 3'b111, 20, 22, 21, 1, 2, 22, 2, 3'b101);
        add(0, 1, 3'b010, 0, 23, 0, 0, 0, 22, 2, 3'b000);
        idle(0, 0, 22, 2, 3'b000);
        idle(0, 0, 22, 2, 3'b000);
        // Single source back to back, never stalled.
        for (int k = 1; k <= 8; k++) add(0, 0, 3'b100, 0, 0, k, 1, 3, k, 3, 3'b000);
        idle(0, 0, 8, 3, 3'b000);
        // Register x0 is emitted like any other entry.
        add(0, 0, 3'b001, 0, 0, 0, 1, 1, 0, 1, 3'b000);
        idle(0, 0, 0, 1, 3'b000);
        // Mid-operation reset with two slots full and counters running.
        add(0, 0, 3'b111, 25, 26, 27, 1, 2, 26, 2, 3'b101);
        add(0, 0, 3'b010, 0, 28, 0, 1, 2, 28, 2, 3'b101);
        add(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        idle(0, 0, 0, 0, 3'b000);
        // After reset, exe needs the full STARVE_LIMIT wait again.
        add(0, 0, 3'b011, 9, 29, 0, 1, 2, 29, 2, 3'b001);
        add(0, 0, 3'b010, 0, 30, 0, 1, 2, 30, 2, 3'b001);
        add(0, 0, 3'b010, 0, 31, 0, 1, 2, 31, 2, 3'b001);
        add(0, 0, 3'b010, 0, 1, 0, 1, 2, 1, 2, 3'b001);
        add(0, 0, 3'b010, 0, 2, 0, 1, 2, 2, 2, 3'b001);
        add(0, 0, 3'b010, 0, 3, 0, 1, 1, 9, 1, 3'b010);
        idle(1, 2, 3, 2, 3'b000);
        idle(0, 0, 3, 2, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v, e;
            v = vecs[i];
            @(negedge clk);
            rst_i = v.rst; kill_i = v.kill;
            exe_valid_i = v.vld[0]; mult5_valid_i = v.vld[1]; cache_valid_i = v.vld[2];
            exe_a = v.ae; mult5_a = v.am; cache_a = v.ac;
            exp_q.push_back(v);
            #1;
            if ((exe_valid_i && exe_stall_o) || (mult5_valid_i && mult5_stall_o) ||
                (cache_valid_i && cache_stall_o)) begin
                n_err++;
                $display("FAIL v%0d protocol: valid asserted against stall %b", i,
                         {cache_stall_o, mult5_stall_o, exe_stall_o});
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            chk("enable", i, 32'(wen), 32'(e.en));
            chk("grant_src", i, 32'(wsrc), 32'(e.src));
            chk("addr", i, 32'(waddr), 32'(e.addr));
            chk("data", i, wdata, f_data(e.dsrc, e.addr));
            chk("exc", i, wexc, f_exc(e.dsrc, e.addr));
            chk("instruction", i, winstr, f_ins(e.dsrc, e.addr));
            chk("pc", i, wpc, f_pc(e.dsrc, e.addr));
            chk("stalls", i, 32'({cache_stall_o, mult5_stall_o, exe_stall_o}), 32'(e.stall));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
